// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seg_pkg;

    // One BCD digit; values 10..15 are treated as blank by the decoder.
    typedef logic [3:0] bcd_t;

    // All cathodes off, decimal point included (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low cathode patterns {DP,g,f,e,d,c,b,a} for digits 0..9, DP off.
    localparam logic [7:0] SEG_CODES [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD to active-low seven-segment decoder; codes above 9 blank the digit.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_bcd - digit to decode; o_seg - {g,f,e,d,c,b,a}, active-low.
module bcd_to_seg7
    import seg_pkg::*;
(
    input  bcd_t        i_bcd,
    output logic [6:0]  o_seg
);

    always_comb begin
        o_seg = SEG_BLANK[6:0];
        if (i_bcd <= 4'd9) begin
            o_seg = SEG_CODES[i_bcd][6:0];
        end
    end

endmodule

// File: rtl/seg_display_driver.sv
// Multiplexed, PWM-dimmed driver for a common-anode 4-digit seven-segment display.
// Latency: outputs are registered, one cycle behind the scan/PWM state.
// Backpressure: none; digit inputs are snapshotted once per scan frame.
// Ports: CLK100MHZ/nReset - clock and async active-low reset;
//        Digit3..Digit0, DpMask, Brightness - display content and dimming level;
//        SegmentDrivers - active-low anode enables; SevenSegment - active-low cathodes.
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,  // cycles per digit slot, >= 2
    parameter int PWM_DIV     = 16       // cycles per PWM counter step, >= 1
)(
    input  logic        CLK100MHZ,
    input  logic        nReset,
    input  logic [3:0]  Digit3,
    input  logic [3:0]  Digit2,
    input  logic [3:0]  Digit1,
    input  logic [3:0]  Digit0,
    input  logic [3:0]  DpMask,
    input  logic [3:0]  Brightness,
    output logic [3:0]  SegmentDrivers,
    output logic [7:0]  SevenSegment
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] PDIV_LAST  = DW'(PWM_DIV - 1);

    logic [PW-1:0]  r_presc;
    logic [1:0]     r_idx;
    bcd_t [3:0]     r_snap;
    logic [3:0]     r_snap_dp;
    logic [DW-1:0]  r_pwm_div;
    logic [3:0]     r_pwm_cnt;

    logic           w_slot_tick;
    logic           w_pwm_step;
    logic           w_pwm_on;
    bcd_t           w_sel_bcd;
    logic [6:0]     w_seg7;

    assign w_slot_tick = (r_presc == PRESC_LAST);
    assign w_pwm_step  = (r_pwm_div == PDIV_LAST);
    assign w_pwm_on    = (Brightness == 4'hF) || (r_pwm_cnt < Brightness);
    assign w_sel_bcd   = r_snap[r_idx];

    bcd_to_seg7 u_dec (
        .i_bcd (w_sel_bcd),
        .o_seg (w_seg7)
    );

    always_ff @(posedge CLK100MHZ or negedge nReset) begin
        if (!nReset) begin
            r_presc        <= '0;
            r_idx          <= 2'd0;
            r_snap         <= '0;
            r_snap_dp      <= 4'd0;
            r_pwm_div      <= '0;
            r_pwm_cnt      <= 4'd0;
            SegmentDrivers <= 4'b1111;
            SevenSegment   <= SEG_BLANK;
        end else begin
            // Digit-slot prescaler and scan index.
            if (w_slot_tick) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // Capture a whole frame's worth of content only at the frame
            // boundary so a time update can never split across digits.
            if (w_slot_tick && (r_idx == 2'd3)) begin
                r_snap    <= {Digit3, Digit2, Digit1, Digit0};
                r_snap_dp <= DpMask;
            end

            // PWM phase counter; wraps naturally at 15 -> 0.
            if (w_pwm_step) begin
                r_pwm_div <= '0;
                r_pwm_cnt <= r_pwm_cnt + 4'd1;
            end else begin
                r_pwm_div <= r_pwm_div + 1'b1;
            end

            SevenSegment <= {~r_snap_dp[r_idx], w_seg7};

            // The register loading at a slot_tick edge would still show the
            // outgoing digit; blank it so adjacent digits never overlap.
            if (w_slot_tick || !w_pwm_on) begin
                SegmentDrivers <= 4'b1111;
            end else begin
                SegmentDrivers <= ~(4'b0001 << r_idx);
            end
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver with a time-based reference model.
// Latency: model predicts outputs one edge after the scan state they reflect.
// Backpressure: n/a.
module tb_seg_display_driver;

    localparam int R  = 4;
    localparam int PD = 1;

    logic       CLK100MHZ = 1'b0;
    logic       nReset    = 1'b0;
    logic [3:0] Digit3, Digit2, Digit1, Digit0;
    logic [3:0] DpMask, Brightness;
    logic [3:0] SegmentDrivers;
    logic [7:0] SevenSegment;

    int n_cmp = 0;
    int n_err = 0;
    int obs   = 0;

    seg_display_driver #(.REFRESH_DIV(R), .PWM_DIV(PD)) dut (
        .CLK100MHZ      (CLK100MHZ),
        .nReset         (nReset),
        .Digit3         (Digit3),
        .Digit2         (Digit2),
        .Digit1         (Digit1),
        .Digit0         (Digit0),
        .DpMask         (DpMask),
        .Brightness     (Brightness),
        .SegmentDrivers (SegmentDrivers),
        .SevenSegment   (SevenSegment)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // ---------------- reference model ----------------
    // k counts clock edges since reset release; slot, position in slot and
    // PWM phase are derived from it arithmetically.
    logic [7:0] code_tbl [0:9];
    initial begin
        code_tbl[0] = 8'hC0; code_tbl[1] = 8'hF9; code_tbl[2] = 8'hA4;
        code_tbl[3] = 8'hB0; code_tbl[4] = 8'h99; code_tbl[5] = 8'h92;
        code_tbl[6] = 8'h82; code_tbl[7] = 8'hF8; code_tbl[8] = 8'h80;
        code_tbl[9] = 8'h90;
    end

    function automatic logic [7:0] seg_of(input logic [3:0] d, input logic dp);
        logic [7:0] v;
        v = (d <= 4'd9) ? code_tbl[d] : 8'hFF;
        v[7] = ~dp;
        return v;
    endfunction

    int         k = 0;
    logic [3:0] m_snap [4] = '{default: 4'd0};
    logic [3:0] m_dp  = 4'd0;
    logic [7:0] exp_seg = 8'hFF;
    logic [3:0] exp_an  = 4'hF;

    always @(posedge CLK100MHZ or negedge nReset) begin
        int slot;
        int pos;
        if (!nReset) begin
            k       = 0;
            m_snap  = '{default: 4'd0};
            m_dp    = 4'd0;
            exp_seg = 8'hFF;
            exp_an  = 4'hF;
        end else begin
            slot    = (k / R) % 4;
            pos     = k % R;
            exp_seg = seg_of(m_snap[slot], m_dp[slot]);
            if (pos == R - 1)
                exp_an = 4'hF;
            else if (Brightness == 4'd15 || ((k / PD) % 16) < int'(Brightness))
                exp_an = ~(4'b0001 << slot);
            else
                exp_an = 4'hF;
            if (pos == R - 1 && slot == 3) begin
                m_snap = '{Digit0, Digit1, Digit2, Digit3};
                m_dp   = DpMask;
            end
            k++;
        end
    end

    // Continuous comparison against the model on every falling edge.
    always @(negedge CLK100MHZ) begin
        n_cmp++;
        if (SevenSegment !== exp_seg) begin
            n_err++;
            $display("FAIL model_seg t=%0t: got %h expected %h", $time, SevenSegment, exp_seg);
        end
        n_cmp++;
        if (SegmentDrivers !== exp_an) begin
            n_err++;
            $display("FAIL model_an t=%0t: got %b expected %b", $time, SegmentDrivers, exp_an);
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input int t);
        while (obs < t) begin
            @(negedge CLK100MHZ);
            obs++;
        end
    endtask

    initial begin
        int dark;
        Digit3 = 4'd1; Digit2 = 4'd2; Digit1 = 4'd3; Digit0 = 4'd4;
        DpMask = 4'b0000; Brightness = 4'd15;
        repeat (3) @(negedge CLK100MHZ);
        chk("reset_seg", SevenSegment, 8'hFF);
        chk("reset_an", SegmentDrivers, 4'hF);
        nReset = 1'b1;
        obs = -1;

        // First frame: zero snapshot shows 0000.
        step(0);  chk("f1_d0_seg", SevenSegment, 8'hC0); chk("f1_d0_an", SegmentDrivers, 4'b1110);
        step(3);  chk("f1_guard", SegmentDrivers, 4'b1111);
        step(12); chk("f1_d3_seg", SevenSegment, 8'hC0); chk("f1_d3_an", SegmentDrivers, 4'b0111);
        // Second frame: captured 1,2,3,4.
        step(16); chk("f2_d0_seg", SevenSegment, 8'h99); chk("f2_d0_an", SegmentDrivers, 4'b1110);
        step(20); chk("f2_d1_seg", SevenSegment, 8'hB0); chk("f2_d1_an", SegmentDrivers, 4'b1101);
        Digit0 = 4'd9;
        step(24); chk("f2_d2_seg", SevenSegment, 8'hA4); chk("f2_d2_an", SegmentDrivers, 4'b1011);
        step(28); chk("f2_d3_seg", SevenSegment, 8'hF9); chk("f2_d3_an", SegmentDrivers, 4'b0111);
        // Tearing: change mid-frame stays invisible until the next frame.
        step(32); chk("tear_before", SevenSegment, 8'h90);
        step(33); Digit0 = 4'd5;
        step(34); chk("tear_same_frame", SevenSegment, 8'h90);
        step(40); Digit1 = 4'hC; DpMask = 4'b0100;
        step(48); chk("tear_next_frame", SevenSegment, 8'h92);
        // Blank code and decimal point.
        step(52); chk("blank_d1", SevenSegment, 8'hFF);
        step(56); chk("dp_d2", SevenSegment, 8'h24);
        step(60); chk("nodp_d3", SevenSegment, 8'hF9);
        // Brightness 4: lit only while the PWM phase is below 4.
        step(63); Brightness = 4'd4;
        step(66); chk("pwm4_on", SegmentDrivers, 4'b1110);
        step(68); chk("pwm4_off", SegmentDrivers, 4'b1111);
        step(81); chk("pwm4_on2", SegmentDrivers, 4'b1110);
        // Brightness 0: permanently dark.
        step(95); Brightness = 4'd0;
        dark = 0;
        for (int i = 96; i < 160; i++) begin
            step(i);
            if (SegmentDrivers == 4'b1111) dark++;
        end
        chk("dark_cycles", dark, 64);
        Brightness = 4'd15;
        // Asynchronous reset while digit 2 is being driven.
        step(169); chk("pre_arst_an", SegmentDrivers, 4'b1011);
        #2 nReset = 1'b0;
        #1;
        chk("arst_seg", SevenSegment, 8'hFF);
        chk("arst_an", SegmentDrivers, 4'hF);
        repeat (2) @(negedge CLK100MHZ);
        nReset = 1'b1;
        obs = -1;
        step(0);  chk("post_arst_seg", SevenSegment, 8'hC0); chk("post_arst_an", SegmentDrivers, 4'b1110);
        step(16); chk("post_arst_f2", SevenSegment, 8'h92);
        step(24); chk("post_arst_dp", SevenSegment, 8'h24);
        step(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
